// File: rtl/spi_dac_multi_writer_pkg.sv
// Shared declarations for the multi-channel SPI DAC writer.
//   dac_state_t : FSM states of the frame serialiser
//   offset_bin  : signed two's-complement code -> offset-binary code of width data_w
package dac_pkg;

   // Widest DAC code the writer supports.
   localparam int MAX_DATA_W = 24;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CS_DOWN = 3'd1,
      CLK_HI  = 3'd2,
      CLK_LO  = 3'd3,
      CS_UP   = 3'd4,
      LDAC    = 3'd5
   } dac_state_t;

   // x holds a data_w-bit two's-complement value (zero-extended). Adding the
   // half-scale constant modulo 2^data_w maps the most negative code to 0,
   // zero to midscale and the most positive code to all ones.
   function automatic logic [MAX_DATA_W-1:0] offset_bin(input logic [MAX_DATA_W-1:0] x,
                                                       input int data_w);
      logic [MAX_DATA_W-1:0] half;
      logic [MAX_DATA_W-1:0] mask;
      half = MAX_DATA_W'(1) << (data_w - 1);
      mask = (MAX_DATA_W'(1) << data_w) - MAX_DATA_W'(1);
      return (x + half) & mask;
   endfunction

endpackage

// File: rtl/spi_dac_multi_writer_arb.sv
// Round-robin channel picker, purely combinational.
//   pending     : one bit per channel waiting to be sent
//   last        : index of the channel served most recently
//   grant_valid : 1 when at least one channel is pending
//   grant       : first pending channel found searching upward from last+1, wrapping
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  pending,
   input  logic [IW-1:0] last,
   output logic          grant_valid,
   output logic [IW-1:0] grant
);

   localparam int SW = IW + 1;

   logic [SW-1:0] sum;

   always_comb begin
      grant_valid = 1'b0;
      grant       = last;
      sum         = '0;
      // Candidate i steps 1..N past the last winner, so the last winner
      // itself is considered only after every other channel.
      for (int i = 1; i <= N; i++) begin
         sum = {1'b0, last} + SW'(i);
         if (sum >= SW'(N)) begin
            sum = sum - SW'(N);
         end
         if (!grant_valid && pending[sum[IW-1:0]]) begin
            grant_valid = 1'b1;
            grant       = sum[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/spi_dac_multi_writer.sv
// Multi-channel SPI writer for the board DAC.
// Captures per-channel setpoints into shadow registers, queues the strobed
// channels, sends each as an {address, code} frame MSB first and, once the
// queue has drained, pulses LDAC so every DAC output updates together.
//   clk_i        : system clock
//   reset_ni     : asynchronous active-low reset
//   data_i       : signed setpoints, channel k at [k*DATA_W +: DATA_W]
//   start_i      : per-channel capture strobe, sampled every cycle
//   is_idle_o    : FSM idle and nothing pending
//   spi_clk_o    : SPI clock, idle low, DAC samples on the rising edge
//   spi_mosi_o   : SPI data, MSB first
//   spi_cs_o     : chip select, active low
//   spi_ldac_no  : DAC load strobe, active low
//   dac_reset_no : DAC reset, active low, released one clock after reset_ni
module spi_dac_multi_writer
   import dac_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int NUM_CH      = 4,
   parameter int CLK_DIV     = 1,
   parameter int CS_HIGH_CYC = 2,
   parameter bit OFFSET_BIN  = 1'b1,
   parameter bit LDAC_EN     = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic [NUM_CH*DATA_W-1:0] data_i,
   input  logic [NUM_CH-1:0]        start_i,
   output logic                     is_idle_o,
   output logic                     spi_clk_o,
   output logic                     spi_mosi_o,
   output logic                     spi_cs_o,
   output logic                     spi_ldac_no,
   output logic                     dac_reset_no
);

   localparam int ADDR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;
   localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int FRAME_W  = ADDR_W + DATA_W;
   localparam int BC_W     = $clog2(FRAME_W);
   localparam int DIV_W    = $clog2(CLK_DIV + 1);
   localparam int HOLD_MAX = (CS_HIGH_CYC > 2 * CLK_DIV) ? CS_HIGH_CYC : 2 * CLK_DIV;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [HOLD_W-1:0] CS_LAST   = HOLD_W'(CS_HIGH_CYC - 1);
   localparam logic [HOLD_W-1:0] LDAC_LAST = HOLD_W'(2 * CLK_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_TOP  = HOLD_W'(HOLD_MAX - 1);

   dac_state_t          state;
   dac_state_t          state_next;
   logic [DIV_W-1:0]    div_cnt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [BC_W-1:0]     bit_cnt;
   logic [FRAME_W-1:0]  shift_q;
   logic [FRAME_W-1:0]  frame;
   logic [DATA_W-1:0]   shadow [NUM_CH];
   logic [DATA_W-1:0]   conv   [NUM_CH];
   logic [NUM_CH-1:0]   pending;
   logic [NUM_CH-1:0]   pending_next;
   logic [NUM_CH-1:0]   grant_mask;
   logic [IDX_W-1:0]    last_served;
   logic [IDX_W-1:0]    grant;
   logic                grant_valid;
   logic                load;
   logic                div_last;
   logic                cs_reg;
   logic                sclk_reg;
   logic                ldac_reg;
   logic                idle_reg;
   logic                dac_rst_reg;

   // ---------------- capture: conversion and shadow registers ----------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [DATA_W-1:0] raw;
         assign raw      = data_i[gi*DATA_W +: DATA_W];
         assign conv[gi] = OFFSET_BIN ? DATA_W'(offset_bin(MAX_DATA_W'(raw), DATA_W)) : raw;

         always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
               shadow[gi] <= '0;
            end else if (start_i[gi]) begin
               shadow[gi] <= conv[gi];
            end
         end
      end
   endgenerate

   // ---------------- arbitration ----------------
   rr_arbiter #(.N(NUM_CH)) u_arb (
      .pending     (pending),
      .last        (last_served),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   // Address bits land above the code; with a single channel they shift out.
   assign frame = (FRAME_W'(grant) << DATA_W) | FRAME_W'(shadow[grant]);

   // A new strobe wins over the clear of the channel being loaded, so a
   // channel re-strobed in its own load cycle is sent once more.
   assign grant_mask   = load ? (NUM_CH'(1) << grant) : '0;
   assign pending_next = (pending & ~grant_mask) | start_i;

   assign div_last = (div_cnt == DIV_LAST);

   // ---------------- FSM next state ----------------
   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               state_next = CS_DOWN;
               load       = 1'b1;
            end
         end
         CS_DOWN: if (div_last) state_next = CLK_HI;
         CLK_HI:  if (div_last) state_next = CLK_LO;
         CLK_LO: begin
            if (div_last) begin
               state_next = (bit_cnt == '0) ? CS_UP : CLK_HI;
            end
         end
         CS_UP: begin
            if (hold_cnt == CS_LAST) begin
               if (grant_valid) begin
                  state_next = CS_DOWN;
                  load       = 1'b1;
               end else if (LDAC_EN) begin
                  state_next = LDAC;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         LDAC: if (hold_cnt == LDAC_LAST) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- state, counters, datapath, outputs ----------------
   // Pin outputs are registered from the current state, so they trail the
   // state by one clock. MOSI shifts on the clock that drives spi_clk_o low,
   // giving the DAC a full half-period of setup before the next rising edge.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state       <= IDLE;
         div_cnt     <= '0;
         hold_cnt    <= '0;
         bit_cnt     <= '0;
         shift_q     <= '0;
         pending     <= '0;
         last_served <= IDX_W'(NUM_CH - 1);
         cs_reg      <= 1'b1;
         sclk_reg    <= 1'b0;
         ldac_reg    <= 1'b1;
         idle_reg    <= 1'b1;
         dac_rst_reg <= 1'b0;
      end else begin
         state   <= state_next;
         pending <= pending_next;

         if (state_next != state || div_last) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end

         if (state_next != state) begin
            hold_cnt <= '0;
         end else if (hold_cnt != HOLD_TOP) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end

         if (load) begin
            bit_cnt     <= BC_W'(FRAME_W - 1);
            shift_q     <= frame;
            last_served <= grant;
         end else begin
            if (state == CLK_LO && div_last && bit_cnt != '0) begin
               bit_cnt <= bit_cnt - BC_W'(1);
            end
            if (state == CLK_LO && div_cnt == '0) begin
               shift_q <= shift_q << 1;
            end
         end

         cs_reg      <= !(state inside {CS_DOWN, CLK_HI, CLK_LO});
         sclk_reg    <= (state == CLK_HI);
         ldac_reg    <= (state != LDAC);
         idle_reg    <= (state_next == IDLE) && (pending_next == '0);
         dac_rst_reg <= 1'b1;
      end
   end

   assign spi_cs_o     = cs_reg;
   assign spi_clk_o    = sclk_reg;
   assign spi_ldac_no  = ldac_reg;
   assign is_idle_o    = idle_reg;
   assign dac_reset_no = dac_rst_reg;
   assign spi_mosi_o   = shift_q[FRAME_W-1];

endmodule
